// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding, common to the
// baud generator, the transmitter and the receiver.
package uart_pkg;

   localparam int UART_OSR    = 16;
   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin input, with a
// selectable reset level so idle-high lines come out of reset idle.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start detect, centre sampling on the oversample tick,
// stop-bit check, and a one-word holding register with valid/ready.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OSR    = UART_OSR,
   parameter int DATA_W = UART_DATA_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              en_i,
   input  logic              osr_tick_i,
   input  logic              rx_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic              frame_err_o,
   output logic              overrun_o
);

   localparam int CNT_W = $clog2(OSR);
   localparam int IDX_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OSR / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OSR - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

   logic              w_rx_s;
   rx_state_t         r_state;
   rx_state_t         w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idx_next;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_next;
   logic              w_word_done;
   logic              w_frame_err;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_frame_err;
   logic              r_overrun;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (rx_i),
      .q_o     (w_rx_s)
   );

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      w_word_done  = 1'b0;
      w_frame_err  = 1'b0;
      if (!en_i) begin
         w_state_next = IDLE;
         w_cnt_next   = '0;
         w_idx_next   = '0;
      end else if (osr_tick_i) begin
         case (r_state)
            IDLE: begin
               if (!w_rx_s) begin
                  w_state_next = START;
                  w_cnt_next   = '0;
               end
            end
            START: begin
               if (r_cnt == HALF_LAST) begin
                  // Line back high at the start-bit centre: treat as noise.
                  w_state_next = w_rx_s ? IDLE : DATA;
                  w_cnt_next   = '0;
                  w_idx_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (r_cnt == FULL_LAST) begin
                  w_shift_next = {w_rx_s, r_shift[DATA_W-1:1]};
                  w_cnt_next   = '0;
                  w_idx_next   = r_idx + 1'b1;
                  if (r_idx == IDX_LAST) begin
                     w_state_next = STOP;
                  end
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            STOP: begin
               if (r_cnt == FULL_LAST) begin
                  w_word_done  = w_rx_s;
                  w_frame_err  = !w_rx_s;
                  w_state_next = IDLE;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            default: begin
               w_state_next = IDLE;
               w_cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_idx       <= w_idx_next;
         r_shift     <= w_shift_next;
         r_frame_err <= w_frame_err;
         r_overrun   <= w_word_done && r_valid && !rx_ready_i;
         // A word being drained this cycle frees the holding register.
         if (w_word_done && (!r_valid || rx_ready_i)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && rx_ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_data_o   = r_data;
   assign rx_valid_o  = r_valid;
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OSR=16, tick every 4 clocks, 64-clock bits.
module tb_uart_rx;

   localparam int BIT_CLKS = 64;

   logic       clk;
   logic       reset;
   logic       en;
   logic       osr_tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   int n_vec = 0;
   int n_err = 0;

   int         valid_cyc = 0;
   int         acc_cnt   = 0;
   int         fe_cyc    = 0;
   int         ov_cyc    = 0;
   logic [7:0] last_acc  = 8'h00;

   int s_valid, s_acc, s_fe, s_ov;

   uart_rx #(
      .OSR    (16),
      .DATA_W (8)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .en_i        (en),
      .osr_tick_i  (osr_tick),
      .rx_i        (rx),
      .rx_data_o   (rx_data),
      .rx_valid_o  (rx_valid),
      .rx_ready_i  (rx_ready),
      .frame_err_o (frame_err),
      .overrun_o   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      osr_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         osr_tick = 1'b1;
         @(negedge clk);
         osr_tick = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (rx_valid) valid_cyc++;
         if (frame_err) fe_cyc++;
         if (overrun) ov_cyc++;
         if (rx_valid && rx_ready) begin
            acc_cnt++;
            last_acc = rx_data;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = data[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = stop_bit;
      repeat (BIT_CLKS) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic set_ready(input logic val);
      @(posedge clk);
      #1 rx_ready = val;
   endtask

   task automatic snap();
      s_valid = valid_cyc;
      s_acc   = acc_cnt;
      s_fe    = fe_cyc;
      s_ov    = ov_cyc;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   initial begin
      reset    = 1'b1;
      en       = 1'b1;
      rx       = 1'b1;
      rx_ready = 1'b1;
      settle(3);
      check_val("reset_data", 32'(rx_data), 32'h00);
      check_val("reset_valid", 32'(rx_valid), 32'h0);
      check_val("reset_ferr", 32'(frame_err), 32'h0);
      check_val("reset_ovr", 32'(overrun), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      settle(20);

      // Clean frame, consumer always ready
      snap();
      send_frame(8'hA5, 1'b1);
      settle(20);
      $display("frame A5: valid_cycles=%0d accepted=%0d data=0x%0h", valid_cyc - s_valid, acc_cnt - s_acc, last_acc);
      check_val("a5_valid_cycles", 32'(valid_cyc - s_valid), 32'd1);
      check_val("a5_accepted", 32'(acc_cnt - s_acc), 32'd1);
      check_val("a5_data", 32'(last_acc), 32'hA5);
      check_val("a5_ferr", 32'(fe_cyc - s_fe), 32'd0);
      check_val("a5_ovr", 32'(ov_cyc - s_ov), 32'd0);

      // Short low glitch is rejected at the start-bit centre
      snap();
      @(negedge clk);
      rx = 1'b0;
      repeat (16) @(negedge clk);
      rx = 1'b1;
      settle(200);
      $display("glitch: valid_cycles=%0d ferr=%0d", valid_cyc - s_valid, fe_cyc - s_fe);
      check_val("glitch_valid", 32'(valid_cyc - s_valid), 32'd0);
      check_val("glitch_ferr", 32'(fe_cyc - s_fe), 32'd0);
      check_val("glitch_ovr", 32'(ov_cyc - s_ov), 32'd0);

      // Stop bit low
      snap();
      send_frame(8'h3C, 1'b0);
      settle(150);
      $display("frame 3C bad stop: ferr_cycles=%0d valid_cycles=%0d", fe_cyc - s_fe, valid_cyc - s_valid);
      check_val("3c_ferr_pulse", 32'(fe_cyc - s_fe), 32'd1);
      check_val("3c_valid", 32'(valid_cyc - s_valid), 32'd0);
      check_val("3c_ovr", 32'(ov_cyc - s_ov), 32'd0);

      // Overrun with the consumer stalled
      set_ready(1'b0);
      snap();
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      settle(20);
      $display("frames 11,22 stalled: data=0x%0h valid=%0d overruns=%0d", rx_data, rx_valid, ov_cyc - s_ov);
      check_val("ovr_valid_held", 32'(rx_valid), 32'h1);
      check_val("ovr_data_held", 32'(rx_data), 32'h11);
      check_val("ovr_pulse", 32'(ov_cyc - s_ov), 32'd1);
      check_val("ovr_no_accept", 32'(acc_cnt - s_acc), 32'd0);
      set_ready(1'b1);
      set_ready(1'b0);
      settle(1);
      $display("drain: valid=%0d accepted=0x%0h", rx_valid, last_acc);
      check_val("drain_valid_low", 32'(rx_valid), 32'h0);
      check_val("drain_accepted", 32'(acc_cnt - s_acc), 32'd1);
      check_val("drain_data", 32'(last_acc), 32'h11);

      // Asynchronous reset mid-frame with a word held
      send_frame(8'h77, 1'b1);
      settle(20);
      check_val("pre_reset_valid", 32'(rx_valid), 32'h1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (BIT_CLKS * 4) @(negedge clk);
            reset = 1'b1;
            #1;
            $display("async reset: data=0x%0h valid=%0d", rx_data, rx_valid);
            check_val("areset_data", 32'(rx_data), 32'h00);
            check_val("areset_valid", 32'(rx_valid), 32'h0);
            check_val("areset_ferr", 32'(frame_err), 32'h0);
            check_val("areset_ovr", 32'(overrun), 32'h0);
            repeat (3) @(negedge clk);
            reset = 1'b0;
         end
      join
      set_ready(1'b1);
      settle(20);
      snap();
      send_frame(8'h5A, 1'b1);
      settle(20);
      $display("frame 5A after reset: accepted=%0d data=0x%0h", acc_cnt - s_acc, last_acc);
      check_val("5a_accepted", 32'(acc_cnt - s_acc), 32'd1);
      check_val("5a_data", 32'(last_acc), 32'h5A);
      check_val("5a_ferr", 32'(fe_cyc - s_fe), 32'd0);

      // Enable dropped during bit 3, restored on an idle line
      snap();
      fork
         send_frame(8'h00, 1'b1);
         begin
            repeat (BIT_CLKS * 4 + 32) @(negedge clk);
            en = 1'b0;
         end
      join
      settle(10);
      en = 1'b1;
      settle(40);
      $display("disabled frame: valid_cycles=%0d ferr=%0d", valid_cyc - s_valid, fe_cyc - s_fe);
      check_val("dis_valid", 32'(valid_cyc - s_valid), 32'd0);
      check_val("dis_ferr", 32'(fe_cyc - s_fe), 32'd0);
      snap();
      send_frame(8'hC3, 1'b1);
      settle(20);
      $display("frame C3 after enable: accepted=%0d data=0x%0h", acc_cnt - s_acc, last_acc);
      check_val("c3_accepted", 32'(acc_cnt - s_acc), 32'd1);
      check_val("c3_data", 32'(last_acc), 32'hC3);
      check_val("c3_ferr", 32'(fe_cyc - s_fe), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
